// File: rtl/als_mon_pkg.sv
// Shared types and default sizes for the adder error-monitor family.
// The run FSM encoding is shared so that monitors and benches agree on state values.
package als_mon_pkg;

  localparam int WIDTH_DEF     = 17;
  localparam int N_SAMPLES_DEF = 100000;
  localparam int CNT_W_DEF     = 17;
  localparam int ACC_W_DEF     = 34;
  localparam int DRAIN_CYCLES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

endpackage

// File: rtl/als_error_monitor_if.sv
// Sample-pair stream into the error monitor.
// valid/ready: a pair transfers on a rising edge where in_valid && in_ready; the source holds data while in_valid is high.
interface als_error_monitor_if
  import als_mon_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] exact_in;
  logic [WIDTH-1:0] approx_in;

  modport master (output in_valid, output exact_in, output approx_in, input in_ready);
  modport slave  (input in_valid, input exact_in, input approx_in, output in_ready);

endinterface

// File: rtl/als_abs_diff.sv
// Unsigned absolute difference (larger minus smaller) plus a mismatch flag.
// Purely combinational so it can feed any monitor's first pipeline stage.
module als_abs_diff
  import als_mon_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             mismatch_o
);

  always_comb begin
    diff_o     = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
    mismatch_o = (a_i != b_i);
  end

endmodule

// File: rtl/als_error_monitor.sv
// Streams exact/approximate adder results and accumulates error count, sum and
// maximum of absolute error distance over a fixed-length run.
module als_error_monitor
  import als_mon_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             done_ack,
  als_error_monitor_if.slave s_if,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [WIDTH-1:0] max_abs_err,
  output logic             acc_sat,
  output mon_state_e       dbg_state
);

  localparam logic [CNT_W-1:0] N_MAX     = CNT_W'(N_SAMPLES);
  localparam logic [1:0]       DRAIN_END = 2'(DRAIN_CYCLES - 1);

  mon_state_e       state_q, state_d;
  logic [1:0]       drain_q, drain_d;
  logic             clear;

  logic [CNT_W-1:0] sample_count_q, err_count_q, count_inc;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W:0]   sum_wide;
  logic             sum_ovf;
  logic [WIDTH-1:0] max_q;
  logic             sat_q;

  logic             v1_q, mis1_q;
  logic [WIDTH-1:0] d1_q;
  logic [WIDTH-1:0] diff;
  logic             mismatch;
  logic             in_ready;
  logic             accept;

  als_abs_diff #(.WIDTH(WIDTH)) u_abs_diff (
    .a_i        (s_if.exact_in),
    .b_i        (s_if.approx_in),
    .diff_o     (diff),
    .mismatch_o (mismatch)
  );

  assign in_ready  = (state_q == ST_RUN) && (sample_count_q < N_MAX);
  assign accept    = s_if.in_valid && in_ready;
  assign count_inc = sample_count_q + CNT_W'(1);

  // Start wins over done_ack in DONE; start is ignored while a run is live.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept && (count_inc == N_MAX)) begin
          state_d = ST_DRAIN;
          drain_d = 2'd0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_END) state_d = ST_DONE;
        else                      drain_d = drain_q + 2'd1;
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end else if (done_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Saturating accumulate: any carry out of ACC_W pins the sum at all-ones.
  always_comb begin
    sum_wide = {1'b0, sum_q} + (ACC_W + 1)'(d1_q);
    sum_ovf  = sum_wide[ACC_W];
    sum_d    = sum_ovf ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count_q <= '0;
      err_count_q    <= '0;
      sum_q          <= '0;
      max_q          <= '0;
      sat_q          <= 1'b0;
      v1_q           <= 1'b0;
      mis1_q         <= 1'b0;
      d1_q           <= '0;
    end else if (clear) begin
      sample_count_q <= '0;
      err_count_q    <= '0;
      sum_q          <= '0;
      max_q          <= '0;
      sat_q          <= 1'b0;
      v1_q           <= 1'b0;
      mis1_q         <= 1'b0;
      d1_q           <= '0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        sample_count_q <= count_inc;
        d1_q           <= diff;
        mis1_q         <= mismatch;
      end
      if (v1_q) begin
        err_count_q <= err_count_q + CNT_W'(mis1_q);
        sum_q       <= sum_d;
        sat_q       <= sat_q | sum_ovf;
        if (d1_q > max_q) max_q <= d1_q;
      end
    end
  end

  assign s_if.in_ready = in_ready;
  assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);
  assign sample_count  = sample_count_q;
  assign err_count     = err_count_q;
  assign sum_abs_err   = sum_q;
  assign max_abs_err   = max_q;
  assign acc_sat       = sat_q;
  assign dbg_state     = state_q;

endmodule
